// File: rtl/opcode_fetch_fifo.sv
// -----------------------------------------------------------------------------
// opcode_fetch_fifo
//
// Show-ahead FIFO between the instruction source and the combinational
// opcode-type decoder. The head entry is always presented on out_opcode.
// out_opcode is forced to zero whenever the FIFO is empty.
//
// A synchronous flush handles pipeline redirects. A sticky drop_err flags any
// attempt by the producer to present data while the FIFO is full.
//
// All outputs come straight from registers. Each register is loaded with the
// value that the output must show after the edge. This means no path exists
// from in_valid or out_ready to any output.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous clear of all entries and of drop_err
//   in_valid   : producer has an opcode on in_opcode
//   in_opcode  : opcode to enqueue
//   in_ready   : FIFO can accept (count != DEPTH)
//   out_valid  : head entry available (count != 0)
//   out_opcode : head entry, zero when out_valid = 0
//   out_ready  : decoder consumes the head this cycle
//   count      : current occupancy, 0..DEPTH
//   drop_err   : sticky, set when in_valid = 1 while in_ready = 0
// -----------------------------------------------------------------------------
module opcode_fetch_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_opcode,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_opcode,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              drop_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              drop_err_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_opcode_r;

    logic              push_s;
    logic              pop_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              drop_err_nxt_s;
    logic              in_ready_nxt_s;
    logic              out_valid_nxt_s;
    logic [DATA_W-1:0] head_nxt_s;

    // Handshakes qualified by the registered flags only
    always_comb begin
        push_s = in_valid & in_ready_r;
        pop_s  = out_valid_r & out_ready;
    end

    // Next-state computation for pointers, count, sticky error and output flags
    always_comb begin
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        count_nxt_s    = count_r;
        drop_err_nxt_s = drop_err_r;
        head_nxt_s     = {DATA_W{1'b0}};

        if (flush) begin
            wr_ptr_nxt_s   = {PTR_W{1'b0}};
            rd_ptr_nxt_s   = {PTR_W{1'b0}};
            count_nxt_s    = {CNT_W{1'b0}};
            drop_err_nxt_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase

            // A rejected push discards the data; only the sticky flag records it
            if (in_valid & ~in_ready_r) begin
                drop_err_nxt_s = 1'b1;
            end else begin
                drop_err_nxt_s = drop_err_r;
            end
        end

        in_ready_nxt_s  = (count_nxt_s != CNT_W'(DEPTH));
        out_valid_nxt_s = (count_nxt_s != {CNT_W{1'b0}});

        // Head after the edge. When the FIFO is empty, or when its only entry
        // leaves this cycle, the new head is the opcode being pushed now. In
        // every other case the new head already sits in the array.
        if (flush || (count_nxt_s == {CNT_W{1'b0}})) begin
            head_nxt_s = {DATA_W{1'b0}};
        end else if ((count_r == {CNT_W{1'b0}}) ||
                     ((count_r == CNT_W'(1)) && pop_s)) begin
            head_nxt_s = in_opcode;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage; a flush leaves contents as don't-care
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= in_opcode;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            drop_err_r   <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_opcode_r <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            drop_err_r   <= drop_err_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_opcode_r <= head_nxt_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_opcode = out_opcode_r;
    assign count      = count_r;
    assign drop_err   = drop_err_r;

endmodule
